// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch timebase/BCD core.
// Used by stopwatch_core and bcd_digit.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      FULL
   } sw_state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIG0_MAX = 4'd9;
   localparam bcd_t DIG1_MAX = 4'd9;
   localparam bcd_t DIG2_MAX = 4'd5;
   localparam bcd_t DIG3_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit that wraps at MAX.
// carry is combinational so a chain of digits ripples within one cycle.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = 4'd9
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output bcd_t q,
   output logic carry
);

   bcd_t q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (inc)
         q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q_q <= '0;
      else
         q_q <= q_d;
   end

   assign q     = q_q;
   assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timebase and M:SS.t BCD counter with run/pause/clear FSM.
// Optional lap hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start_stop,
   input  logic clear,
`ifdef STOPWATCH_LAP_EN
   input  logic lap,
   output logic lap_active,
`endif
   output bcd_t d0,
   output bcd_t d1,
   output bcd_t d2,
   output bcd_t d3,
   output logic running,
   output logic overflow
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

   sw_state_t       state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            run_q, full_q;
   logic            tick, at_max, full_go;
   logic [3:0]      inc, c;
   bcd_t            dig0, dig1, dig2, dig3;
   logic            unused_carry;

   assign tick   = (state_q == RUN) && (presc_q == PS_LAST);
   assign at_max = (dig0 == DIG0_MAX) && (dig1 == DIG1_MAX) &&
                   (dig2 == DIG2_MAX) && (dig3 == DIG3_MAX);

   // At 9:59.9 the tick saturates into FULL instead of rolling the digits.
   assign full_go = tick && at_max;
   assign inc     = {c[2:0], tick && !at_max};
   assign unused_carry = c[3];

   bcd_digit #(.MAX(DIG0_MAX)) u_dig0 (
      .clk(clk), .reset(reset), .clr(clear),
      .inc(inc[0]), .q(dig0), .carry(c[0])
   );
   bcd_digit #(.MAX(DIG1_MAX)) u_dig1 (
      .clk(clk), .reset(reset), .clr(clear),
      .inc(inc[1]), .q(dig1), .carry(c[1])
   );
   bcd_digit #(.MAX(DIG2_MAX)) u_dig2 (
      .clk(clk), .reset(reset), .clr(clear),
      .inc(inc[2]), .q(dig2), .carry(c[2])
   );
   bcd_digit #(.MAX(DIG3_MAX)) u_dig3 (
      .clk(clk), .reset(reset), .clr(clear),
      .inc(inc[3]), .q(dig3), .carry(c[3])
   );

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      if (state_q == RUN)
         presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PW'(1);
      unique case (state_q)
         IDLE:    if (start_stop) state_d = RUN;
         RUN: begin
            if (full_go)
               state_d = FULL;
            else if (start_stop)
               state_d = PAUSE;
         end
         PAUSE:   if (start_stop) state_d = RUN;
         FULL:    state_d = FULL;
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = IDLE;
         presc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         run_q   <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         run_q   <= (state_d == RUN);
         full_q  <= (state_d == FULL);
      end
   end

   assign running  = run_q;
   assign overflow = full_q;

`ifdef STOPWATCH_LAP_EN
   logic        lap_q, lap_d, cap;
   logic [15:0] hold_q;

   always_comb begin
      lap_d = lap_q;
      cap   = 1'b0;
      if (clear)
         lap_d = 1'b0;
      else if (lap) begin
         if (lap_q)
            lap_d = 1'b0;
         else if (state_q == RUN || state_q == PAUSE) begin
            lap_d = 1'b1;
            cap   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lap_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         lap_q <= lap_d;
         if (cap)
            hold_q <= {dig3, dig2, dig1, dig0};
      end
   end

   assign lap_active = lap_q;
   assign d0 = lap_q ? hold_q[3:0]   : dig0;
   assign d1 = lap_q ? hold_q[7:4]   : dig1;
   assign d2 = lap_q ? hold_q[11:8]  : dig2;
   assign d3 = lap_q ? hold_q[15:12] : dig3;
`else
   assign d0 = dig0;
   assign d1 = dig1;
   assign d2 = dig2;
   assign d3 = dig3;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_HZ=100, TICK_HZ=10 (DIV=10).
// Lap checks are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  d0, d1, d2, d3;
   logic        running, overflow;
   logic [15:0] disp;
   int          n_run = 0;
   int          n_fail = 0;
`ifdef STOPWATCH_LAP_EN
   logic        lap = 1'b0;
   logic        lap_active;
`endif

   assign disp = {d3, d2, d1, d0};

   always #5 clk = ~clk;

   stopwatch_core #(
      .CLK_HZ(100),
      .TICK_HZ(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start_stop(start_stop),
      .clear(clear),
`ifdef STOPWATCH_LAP_EN
      .lap(lap),
      .lap_active(lap_active),
`endif
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .d3(d3),
      .running(running),
      .overflow(overflow)
   );

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      cyc(1);
      start_stop = 1'b0;
   endtask

   task automatic pulse_clr();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   initial begin
      cyc(2);
      check("rst_disp", disp, 16'h0000);
      check("rst_run", 16'(running), 16'd0);
      check("rst_ovf", 16'(overflow), 16'd0);
      reset = 1'b0;
      cyc(1);
      check("idle_disp", disp, 16'h0000);

      // start, then 250 edges
      pulse_ss();
      check("start_run", 16'(running), 16'd1);
      cyc(249);
      check("t249", disp, 16'h0024);
      cyc(1);
      check("t250", disp, 16'h0025);
      check("t250_run", 16'(running), 16'd1);

      // carries
      cyc(740);
      check("t_0099", disp, 16'h0099);
      cyc(10);
      check("t_0100", disp, 16'h0100);
      cyc(4990);
      check("t_0599", disp, 16'h0599);
      cyc(10);
      check("t_1000", disp, 16'h1000);

      // saturation
      cyc(53990);
      check("t_9599", disp, 16'h9599);
      check("pre_ovf", 16'(overflow), 16'd0);
      cyc(10);
      check("full_disp", disp, 16'h9599);
      check("full_ovf", 16'(overflow), 16'd1);
      check("full_run", 16'(running), 16'd0);
      pulse_ss();
      cyc(20);
      check("full_ss_disp", disp, 16'h9599);
      check("full_ss_ovf", 16'(overflow), 16'd1);
      check("full_ss_run", 16'(running), 16'd0);
      pulse_clr();
      check("clr_full_disp", disp, 16'h0000);
      check("clr_full_ovf", 16'(overflow), 16'd0);
      check("clr_full_run", 16'(running), 16'd0);

      // pause with prescaler at 6
      pulse_ss();
      cyc(15);
      pulse_ss();
      check("pause_run", 16'(running), 16'd0);
      check("pause_disp0", disp, 16'h0001);
      cyc(100);
      check("pause_disp1", disp, 16'h0001);
      pulse_ss();
      check("resume_run", 16'(running), 16'd1);
      cyc(3);
      check("resume_r3", disp, 16'h0001);
      cyc(1);
      check("resume_r4", disp, 16'h0002);

      // clear with start_stop in the same cycle
      cyc(320);
      check("t_0034", disp, 16'h0034);
      clear = 1'b1;
      start_stop = 1'b1;
      cyc(1);
      clear = 1'b0;
      start_stop = 1'b0;
      check("clr_ss_disp", disp, 16'h0000);
      check("clr_ss_run", 16'(running), 16'd0);
      cyc(20);
      check("clr_ss_idle", disp, 16'h0000);

      // asynchronous reset mid-count
      pulse_ss();
      cyc(37);
      check("pre_rst", disp, 16'h0003);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("arst_disp", disp, 16'h0000);
      check("arst_run", 16'(running), 16'd0);
      #1;
      reset = 1'b0;
      cyc(1);

`ifdef STOPWATCH_LAP_EN
      pulse_ss();
      cyc(120);
      check("lap_pre", disp, 16'h0012);
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      check("lap_hold", disp, 16'h0012);
      check("lap_act", 16'(lap_active), 16'd1);
      cyc(49);
      check("lap_hold2", disp, 16'h0012);
      lap = 1'b1;
      cyc(1);
      lap = 1'b0;
      check("lap_rel", disp, 16'h0017);
      check("lap_inact", 16'(lap_active), 16'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
